// File: rtl/bram_window_reader.sv
`default_nettype none
// ============================================================================
// Module   : bram_window_reader
// Brief    : Walks a 2-D word window out of a 1-cycle-latency BRAM and streams
//            it through a credit-limited skid FIFO. Optional stall counter via
//            READER_STALL_CNT_EN.
// Revision : 1.0
// ============================================================================
module bram_window_reader #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 32,
  parameter int DIM_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] row_pitch,
  input  logic [DIM_W-1:0]  row_len,
  input  logic [DIM_W-1:0]  num_rows,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [DATA_W-1:0] bram_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic [15:0]       stall_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [DIM_W-1:0]  len_r;
  logic [DIM_W-1:0]  rows_r;
  logic [ADDR_W-1:0] pitch_r;
  logic [DIM_W-1:0]  row_r;
  logic [DIM_W-1:0]  col_r;
  logic [ADDR_W-1:0] row_base_r;
  logic [ADDR_W-1:0] next_addr_r;
  logic              rd_last;

  logic              cap;
  logic              cap_last;
  logic [DATA_W:0]   mem [0:FIFO_DEPTH-1];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  mem_cnt;

  logic              w_launch;
  logic              w_zero;
  logic              w_idle;
  logic [CNT_W-1:0]  w_total;
  logic [CNT_W:0]    w_pending;
  logic              w_credit;
  logic              w_issue;
  logic [ADDR_W-1:0] w_cur_addr;
  logic [ADDR_W-1:0] w_cur_base;
  logic [ADDR_W-1:0] w_cur_pitch;
  logic [DIM_W-1:0]  w_cur_row;
  logic [DIM_W-1:0]  w_cur_col;
  logic [DIM_W-1:0]  w_cur_len;
  logic [DIM_W-1:0]  w_cur_rows;
  logic              w_col_end;
  logic              w_last;
  logic [ADDR_W-1:0] w_next_row_base;
  logic              w_head_take;
  logic              w_mem_empty;
  logic              w_mem_push;
  logic              w_mem_pop;

  assign w_idle   = (state == S_IDLE);
  assign w_launch = w_idle && start;
  assign w_zero   = (row_len == '0) || (num_rows == '0);

  // Outstanding words: held in FIFO, on the BRAM bus now, and issued this cycle.
  assign w_total   = mem_cnt + CNT_W'(m_valid);
  assign w_pending = {1'b0, w_total} + (CNT_W+1)'(cap) + (CNT_W+1)'(rd_en);
  assign w_credit  = w_pending < (CNT_W+1)'(FIFO_DEPTH);
  assign w_issue   = (w_launch && !w_zero) || ((state == S_ISSUE) && w_credit);

  // The launch cycle issues word (0,0) straight from the port values.
  assign w_cur_addr  = w_idle ? (base_addr & ~ADDR_W'(3)) : next_addr_r;
  assign w_cur_base  = w_idle ? (base_addr & ~ADDR_W'(3)) : row_base_r;
  assign w_cur_pitch = w_idle ? row_pitch : pitch_r;
  assign w_cur_row   = w_idle ? '0 : row_r;
  assign w_cur_col   = w_idle ? '0 : col_r;
  assign w_cur_len   = w_idle ? row_len : len_r;
  assign w_cur_rows  = w_idle ? num_rows : rows_r;

  assign w_col_end       = (w_cur_col == w_cur_len - DIM_W'(1));
  assign w_last          = w_col_end && (w_cur_row == w_cur_rows - DIM_W'(1));
  assign w_next_row_base = w_cur_base + w_cur_pitch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      len_r       <= '0;
      rows_r      <= '0;
      pitch_r     <= '0;
      row_r       <= '0;
      col_r       <= '0;
      row_base_r  <= '0;
      next_addr_r <= '0;
      rd_addr     <= '0;
      rd_en       <= 1'b0;
      rd_last     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      rd_en   <= w_issue;
      rd_last <= w_issue && w_last;
      done    <= 1'b0;
      if (w_issue) begin
        rd_addr <= w_cur_addr;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            len_r   <= row_len;
            rows_r  <= num_rows;
            pitch_r <= row_pitch;
            busy    <= 1'b1;
            state   <= w_zero ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
        end
        S_DRAIN: begin
          if ((w_total == '0) && !cap && !rd_en) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase

      if (w_issue) begin
        if (w_col_end) begin
          col_r       <= '0;
          row_r       <= w_cur_row + DIM_W'(1);
          row_base_r  <= w_next_row_base;
          next_addr_r <= w_next_row_base;
        end else begin
          col_r       <= w_cur_col + DIM_W'(1);
          row_r       <= w_cur_row;
          row_base_r  <= w_cur_base;
          next_addr_r <= w_cur_addr + ADDR_W'(4);
        end
        if (w_last) begin
          state <= S_DRAIN;
        end
      end
    end
  end

  // Skid FIFO: m_data/m_valid/m_last form the head register, mem backs it up.
  assign w_head_take = !m_valid || m_ready;
  assign w_mem_empty = (mem_cnt == '0);
  assign w_mem_pop   = w_head_take && !w_mem_empty;
  assign w_mem_push  = cap && !(w_head_take && w_mem_empty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap      <= 1'b0;
      cap_last <= 1'b0;
      m_data   <= '0;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_cnt  <= '0;
    end else begin
      cap      <= rd_en;
      cap_last <= rd_last;
      if (w_head_take) begin
        if (!w_mem_empty) begin
          m_data  <= mem[rd_ptr][DATA_W-1:0];
          m_last  <= mem[rd_ptr][DATA_W];
          m_valid <= 1'b1;
        end else if (cap) begin
          m_data  <= bram_data;
          m_last  <= cap_last;
          m_valid <= 1'b1;
        end else begin
          m_valid <= 1'b0;
          m_last  <= 1'b0;
        end
      end
      if (w_mem_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (w_mem_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      mem_cnt <= mem_cnt + CNT_W'(w_mem_push) - CNT_W'(w_mem_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_push) begin
      mem[wr_ptr] <= {cap_last, bram_data};
    end
  end

`ifdef READER_STALL_CNT_EN
  logic [15:0] stall_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_r <= 16'h0000;
    end else if (w_launch) begin
      stall_r <= 16'h0000;
    end else if (m_valid && !m_ready && (stall_r != 16'hFFFF)) begin
      stall_r <= stall_r + 16'h0001;
    end
  end

  assign stall_cnt = stall_r;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bram_window_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_bram_window_reader
// Brief    : Scoreboard bench for bram_window_reader with a behavioural BRAM.
// Revision : 1.0
// ============================================================================
module tb_bram_window_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [19:0] base_addr = '0;
  logic [19:0] row_pitch = '0;
  logic [7:0]  row_len = '0;
  logic [7:0]  num_rows = '0;
  logic        m_ready = 1'b0;
  logic [31:0] bram_data = '0;
  logic [19:0] rd_addr;
  logic        rd_en;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_last;
  logic        busy;
  logic        done;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  bram_window_reader #(
    .ADDR_W(20), .DATA_W(32), .DIM_W(8), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .base_addr(base_addr), .row_pitch(row_pitch),
    .row_len(row_len), .num_rows(num_rows),
    .rd_addr(rd_addr), .rd_en(rd_en), .bram_data(bram_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .done(done), .stall_cnt(stall_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;
  int beat_cnt = 0;
  int done_cnt = 0;
  logic [19:0] exp_addr [$];
  logic [32:0] exp_beat [$];
  logic [19:0] mon_a;
  logic [32:0] mon_b;
  logic        prev_stall = 1'b0;
  logic [32:0] prev_beat = '0;

  function automatic logic [31:0] word_of(input logic [19:0] a);
    return {12'hA50, a};
  endfunction

  // Registered-read BRAM: data for rd_addr appears the cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) bram_data <= word_of(rd_addr);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (rd_en) begin
        if (exp_addr.size() == 0) check("rd_en_unexpected", rd_en, 1'b0);
        else begin
          mon_a = exp_addr.pop_front();
          check("rd_addr", rd_addr, mon_a);
        end
      end
      if (prev_stall) begin
        check("hold_valid", m_valid, 1'b1);
        check("hold_data", {m_last, m_data}, prev_beat);
      end
      prev_stall = m_valid && !m_ready;
      prev_beat  = {m_last, m_data};
      if (m_valid && m_ready) begin
        beat_cnt++;
        if (exp_beat.size() == 0) check("beat_unexpected", m_valid, 1'b0);
        else begin
          mon_b = exp_beat.pop_front();
          check("m_data", m_data, mon_b[31:0]);
          check("m_last", m_last, mon_b[32]);
        end
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic start_window(input logic [19:0] b, input logic [19:0] p,
                              input logic [7:0] l, input logic [7:0] r);
    logic [19:0] a;
    for (int ri = 0; ri < int'(r); ri++) begin
      for (int ci = 0; ci < int'(l); ci++) begin
        a = 20'((b & 20'hFFFFC) + p * ri + 4 * ci);
        exp_addr.push_back(a);
        exp_beat.push_back({(ri == int'(r) - 1) && (ci == int'(l) - 1), word_of(a)});
      end
    end
    @(posedge clk); #1;
    base_addr = b; row_pitch = p; row_len = l; num_rows = r; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int mode, input string tag);
    for (int k = 0; k < 500; k++) begin
      @(negedge clk); #1;
      if (done_cnt != d0) break;
      @(posedge clk); #1;
      case (mode)
        1:       m_ready = ~m_ready;
        2:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b1;
      endcase
    end
    check({tag, "_done"}, done_cnt, d0 + 1);
    check({tag, "_drained"}, exp_beat.size() + exp_addr.size(), 0);
    m_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_done_once"}, done_cnt, d0 + 1);
    check({tag, "_busy_low"}, busy, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_last"}, m_last, 0);
    check({tag, "_m_data"}, m_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_stall"}, stall_cnt, 0);
  endtask

  int d0;
  int b0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Reference window, m_ready high, with latency checks.
    m_ready = 1'b1;
    d0 = done_cnt; b0 = beat_cnt;
    start_window(20'h00100, 20'h00040, 8'd3, 8'd2);
    @(negedge clk);
    check("lat_rd_en", rd_en, 1'b1);
    check("lat_busy", busy, 1'b1);
    check("lat_valid0", m_valid, 1'b0);
    @(negedge clk);
    check("lat_valid1", m_valid, 1'b0);
    @(negedge clk);
    check("lat_valid2", m_valid, 1'b1);
    check("lat_data", m_data, word_of(20'h00100));
    wait_done(d0, 0, "A");
    check("A_beats", beat_cnt - b0, 6);

    // Same window, ready toggling.
    d0 = done_cnt; b0 = beat_cnt;
    start_window(20'h00100, 20'h00040, 8'd3, 8'd2);
    wait_done(d0, 1, "B");
    check("B_beats", beat_cnt - b0, 6);

    // Empty window: done two cycles after start, no traffic.
    d0 = done_cnt;
    start_window(20'h00300, 20'h00010, 8'd0, 8'd5);
    @(negedge clk);
    check("Z_done_c1", done, 1'b0);
    check("Z_busy_c1", busy, 1'b1);
    @(negedge clk);
    check("Z_done_c2", done, 1'b1);
    check("Z_busy_c2", busy, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("Z_done_once", done_cnt, d0 + 1);

    // Address wrap at top of the byte space.
    d0 = done_cnt; b0 = beat_cnt;
    start_window(20'hFFFFC, 20'h00010, 8'd2, 8'd1);
    wait_done(d0, 0, "W");
    check("W_beats", beat_cnt - b0, 2);

    // Abort after three beats with async reset.
    d0 = done_cnt; b0 = beat_cnt;
    start_window(20'h00100, 20'h00040, 8'd3, 8'd2);
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (beat_cnt - b0 >= 3) break;
    end
    check("R_beats", beat_cnt - b0, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    exp_addr.delete();
    exp_beat.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("R_no_done", done_cnt, d0);

    // Full re-run after abort, random back-pressure.
    d0 = done_cnt; b0 = beat_cnt;
    start_window(20'h00100, 20'h00040, 8'd3, 8'd2);
    wait_done(d0, 2, "F");
    check("F_beats", beat_cnt - b0, 6);

    // Stall counter: ten cycles of m_valid with m_ready low.
    m_ready = 1'b0;
    d0 = done_cnt; b0 = beat_cnt;
    start_window(20'h02000, 20'h00000, 8'd4, 8'd1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (m_valid) break;
    end
    check("S_valid", m_valid, 1'b1);
    check("S_cnt0", stall_cnt, 0);
    repeat (10) @(negedge clk);
`ifdef READER_STALL_CNT_EN
    check("S_cnt10", stall_cnt, 10);
`else
    check("S_cnt_off", stall_cnt, 0);
`endif
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_done(d0, 0, "S");
    check("S_beats", beat_cnt - b0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
